// File: rtl/sm_mult_pipe.sv
// Pipelined sign-magnitude multiplier: four half-width partial products, shift-add recombination, 1..3 stages.
// Optional macro SM_MULT_ZERO_SIGN_EN clears the sign of a zero-magnitude product (no negative zero).
module sm_mult_pipe #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      a_in,
  input  logic [W-1:0]      b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W+4:0]    w
);

  localparam int H  = W / 2;
  localparam int MW = 2 * W;
  localparam int OW = 2 * W + 5;

  // One global advance: every stage shifts together or everything holds.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [W-1:0] mag_a, mag_b;
  assign mag_a = {1'b0, a_in[W-2:0]};
  assign mag_b = {1'b0, b_in[W-2:0]};

  logic [H-1:0] a_hi, a_lo, b_hi, b_lo;
  assign a_hi = mag_a[W-1:H];
  assign a_lo = mag_a[H-1:0];
  assign b_hi = mag_b[W-1:H];
  assign b_lo = mag_b[H-1:0];

  logic [W-1:0] pp_hh, pp_hl, pp_lh, pp_ll;
  assign pp_hh = W'(a_hi) * W'(b_hi);
  assign pp_hl = W'(a_hi) * W'(b_lo);
  assign pp_lh = W'(a_lo) * W'(b_hi);
  assign pp_ll = W'(a_lo) * W'(b_lo);

  logic sign_in;
  assign sign_in = a_in[W-1] ^ b_in[W-1];

  // Partial-product stage: registered for STAGES >= 2, pass-through otherwise.
  logic         p_valid, p_sign;
  logic [W-1:0] p_hh, p_hl, p_lh, p_ll;

  if (STAGES >= 2) begin : g_pp_reg
    // NOTE: pipeline state uses non-blocking assignments so every stage samples its
    // predecessor's pre-edge value; blocking here would collapse stages into one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_valid <= 1'b0;
        p_sign  <= 1'b0;
        p_hh    <= '0;
        p_hl    <= '0;
        p_lh    <= '0;
        p_ll    <= '0;
      end else if (adv) begin
        p_valid <= in_valid;
        p_sign  <= sign_in;
        p_hh    <= pp_hh;
        p_hl    <= pp_hl;
        p_lh    <= pp_lh;
        p_ll    <= pp_ll;
      end
    end
  end else begin : g_pp_comb
    assign p_valid = in_valid;
    assign p_sign  = sign_in;
    assign p_hh    = pp_hh;
    assign p_hl    = pp_hl;
    assign p_lh    = pp_lh;
    assign p_ll    = pp_ll;
  end

  // Shift-add recombination; the exact product of (W-1)-bit magnitudes fits in 2W bits.
  logic [MW-1:0] mag;
  assign mag = (MW'(p_hh) << W)
             + ((MW'(p_hl) + MW'(p_lh)) << H)
             + MW'(p_ll);

  logic sign_eff;
`ifdef SM_MULT_ZERO_SIGN_EN
  assign sign_eff = p_sign & (|mag);
`else
  assign sign_eff = p_sign;
`endif

  logic [OW-1:0] w_next;
  assign w_next = {sign_eff, 4'b0000, mag};

  logic          r_valid;
  logic [OW-1:0] r_w;

  // NOTE: data registers are reset too (not just valid bits) so w reads 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_w     <= '0;
    end else if (adv) begin
      r_valid <= p_valid;
      r_w     <= w_next;
    end
  end

  if (STAGES >= 3) begin : g_out_reg
    logic          o_valid;
    logic [OW-1:0] o_w;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        o_valid <= 1'b0;
        o_w     <= '0;
      end else if (adv) begin
        o_valid <= r_valid;
        o_w     <= r_w;
      end
    end

    assign out_valid = o_valid;
    assign w         = o_w;
  end else begin : g_out_direct
    assign out_valid = r_valid;
    assign w         = r_w;
  end

endmodule

// File: tb/tb_sm_mult_pipe.sv
// Scoreboard bench for sm_mult_pipe: directed and random traffic on W=8/STAGES=2, plus
// concurrent sweeps of W=4/STAGES=1 (exhaustive) and W=16/STAGES=3 (random).
module tb_sm_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp   = 0;
  int n_bad   = 0;
  int fin_cnt = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference product from the arithmetic definition: sign XOR, integer magnitude product.
  function automatic logic [63:0] ref_w(input int ww, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m, mg;
    logic        s;
    m  = (64'd1 << (ww - 1)) - 64'd1;
    mg = (a & m) * (b & m);
    s  = a[ww-1] ^ b[ww-1];
`ifdef SM_MULT_ZERO_SIGN_EN
    if (mg == 64'd0) s = 1'b0;
`endif
    return (64'(s) << (2 * ww + 4)) | mg;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int CW = (g == 0) ? 8 : (g == 1) ? 4 : 16;
    localparam int CS = (g == 0) ? 2 : (g == 1) ? 1 : 3;
    localparam int OW = 2 * CW + 5;
    localparam int PW = 2 * CW;
    localparam int NPAIRS = (g == 0) ? 300 : (g == 1) ? 256 : 10000;

    logic          rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] a_in, b_in;
    logic [OW-1:0] w;

    logic [63:0]   exp_q[$];
    int            stamp_q[$];
    int            n_pop   = 0;
    int            adv_cnt = 0;

    sm_mult_pipe #(.W(CW), .STAGES(CS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_in     (a_in),
      .b_in     (b_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .w        (w)
    );

    // Monitor: pushes on acceptance, pops and compares on every output transfer.
    initial begin : mon
      logic          adv, prev_stall;
      logic [OW-1:0] prev_w;
      logic [63:0]   e;
      int            s;
      prev_stall = 1'b0;
      prev_w     = '0;
      forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          exp_q.delete();
          stamp_q.delete();
          prev_stall = 1'b0;
        end else begin
          adv = !out_valid || out_ready;
          check("in_ready", 64'(in_ready), 64'(adv));
          if (prev_stall) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_w", 64'(w), 64'(prev_w));
          end
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check("stale_out", 64'(out_valid), 64'd0);
            end else begin
              e = exp_q.pop_front();
              s = stamp_q.pop_front();
              check("result", 64'(w), e);
              check("latency", 64'(adv_cnt - s), 64'(CS));
              n_pop++;
            end
          end
          if (in_valid && in_ready) begin
            exp_q.push_back(ref_w(CW, 64'(a_in), 64'(b_in)));
            stamp_q.push_back(adv_cnt);
          end
          if (adv) adv_cnt++;
          prev_stall = out_valid && !out_ready;
          prev_w     = w;
        end
      end
    end

    // Random traffic with random backpressure; exhaustive walks all {a,b} in acceptance order.
    task automatic rand_run(input int n, input bit exh);
      int            idx;
      int            start;
      bit            acc;
      logic [PW-1:0] pair;
      idx      = 0;
      start    = n_pop;
      in_valid = 1'b0;
      for (int c = 0; c < 60000 && idx < n; c++) begin
        if (!in_valid) begin
          in_valid = ($urandom_range(0, 7) != 0);
          pair     = exh ? PW'(idx) : PW'({$urandom, $urandom});
          {a_in, b_in} = pair;
        end
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) begin
          idx++;
          in_valid = 1'b0;
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 100 && exp_q.size() > 0; k++) begin
        @(posedge clk);
        #1;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      check("result_count", 64'(n_pop - start), 64'(n));
    endtask

    if (g == 0) begin : g_dir
      // Single pair into an empty pipe; checks acceptance, latency and the exact word.
      task automatic single(input logic [7:0] a, input logic [7:0] b, input logic [63:0] exp,
                            input string nm);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_in      = a;
        b_in      = b;
        @(negedge clk);
        check({nm, "_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat < 10) begin
          @(negedge clk);
          if (out_valid) break;
          @(posedge clk);
          lat++;
        end
        check({nm, "_latency"}, 64'(lat), 64'(CS));
        check(nm, 64'(w), exp);
        @(posedge clk);
        #1;
      endtask

      task automatic backpressure();
        int idx, start;
        bit acc;
        idx       = 0;
        start     = n_pop;
        in_valid  = 1'b1;
        a_in      = 8'($urandom);
        b_in      = 8'($urandom);
        for (int c = 0; c < 40 && idx < 10; c++) begin
          out_ready = !(c >= 3 && c <= 7);
          @(negedge clk);
          if (c >= 3 && c <= 7) check("bp_stall_ready", 64'(in_ready), 64'd0);
          acc = in_ready;
          @(posedge clk);
          #1;
          if (acc) begin
            idx++;
            a_in = 8'($urandom);
            b_in = 8'($urandom);
          end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() > 0; k++) begin
          @(posedge clk);
          #1;
        end
        check("bp_count", 64'(n_pop - start), 64'd10);
      endtask

      task automatic reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a_in      = 8'h11;
        b_in      = 8'h22;
        @(posedge clk);
        #1;
        a_in = 8'h33;
        b_in = 8'h44;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("inflight_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_ready", 64'(in_ready), 64'd1);
        check("rst_mid_w", 64'(w), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check("stale_valid", 64'(out_valid), 64'd0);
          @(posedge clk);
          #1;
        end
        single(8'h02, 8'h03, 64'h000006, "post_reset");
      endtask

      initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        #12;
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_ready", 64'(in_ready), 64'd1);
        check("reset_w", 64'(w), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        single(8'h05, 8'h83, 64'h10000F, "basic");
        single(8'h7F, 8'h7F, 64'h003F01, "max_pos");
        single(8'hFF, 8'hFF, 64'h003F01, "max_neg");
`ifdef SM_MULT_ZERO_SIGN_EN
        single(8'h80, 8'h05, 64'h000000, "neg_zero");
`else
        single(8'h80, 8'h05, 64'h100000, "neg_zero");
`endif
        backpressure();
        reset_mid();
        rand_run(NPAIRS, 1'b0);
        fin_cnt++;
      end
    end else begin : g_sweep
      initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("sweep_reset_valid", 64'(out_valid), 64'd0);
        check("sweep_reset_w", 64'(w), 64'd0);
        rst_n = 1'b1;
        rand_run(NPAIRS, g == 1);
        fin_cnt++;
      end
    end
  end

  initial begin
    for (int i = 0; i < 80000 && fin_cnt < 3; i++) @(posedge clk);
    check("all_done", 64'(fin_cnt), 64'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
